// File: rtl/obs_disp_pkg.sv
// Shared constants and the hex-to-7-segment table for the CPU observation display.
package obs_disp_pkg;

  localparam logic [1:0] SEL_PC    = 2'd0;
  localparam logic [1:0] SEL_IR    = 2'd1;
  localparam logic [1:0] SEL_MDR   = 2'd2;
  localparam logic [1:0] SEL_WDATA = 2'd3;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational nibble to active-low 7-segment encoder.
module hex7seg_enc
  import obs_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex7(nibble_i);
  end

endmodule

// File: rtl/obs_display_scan.sv
// Snapshots one CPU observation word and scans it as 8 hex digits on a
// multiplexed active-low 7-segment display, with per-slot blanking and a change pulse.
module obs_display_scan
  import obs_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic [31:0] ir_in,
  input  logic [31:0] mdr_in,
  input  logic [31:0] wdata_in,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        change_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]     src_word;
  logic [31:0]     snap_q, snap_d;
  logic            change_d;
  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      cur_nibble;
  logic [6:0]      cur_seg;
  logic [7:0]      seg_d, an_d;
  logic            div_wrap;
  logic            blank;

  always_comb begin
    unique case (sel)
      SEL_PC:    src_word = pc_in;
      SEL_IR:    src_word = ir_in;
      SEL_MDR:   src_word = mdr_in;
      SEL_WDATA: src_word = wdata_in;
      default:   src_word = pc_in;
    endcase
  end

  always_comb begin
    snap_d   = snap_q;
    change_d = 1'b0;
    if (!freeze) begin
      snap_d   = src_word;
      change_d = (src_word != snap_q);
    end
  end

  always_comb begin
    div_wrap  = (div_cnt_q == CntW'(SCAN_DIV - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + CntW'(1);
    idx_d     = div_wrap ? idx_q + 3'd1 : idx_q;
  end

  assign cur_nibble = snap_q[{idx_q, 2'b00} +: 4];

  hex7seg_enc u_hex7seg_enc (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Digit outputs are derived from the pre-edge counter/snapshot state.
  always_comb begin
    blank = (32'(div_cnt_q) < BLANK_CYC);
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!blank) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = {(idx_q != {1'b0, sel}), cur_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q    <= '0;
      div_cnt_q <= '0;
      idx_q     <= '0;
      an_o      <= AN_OFF;
      seg_o     <= SEG_OFF;
      change_o  <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      an_o      <= an_d;
      seg_o     <= seg_d;
      change_o  <= change_d;
    end
  end

endmodule

// File: tb/tb_obs_display_scan.sv
// Randomized self-checking bench for obs_display_scan against a cycle-count display model.
module tb_obs_display_scan;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        freeze;
  logic [31:0] pc_in, ir_in, mdr_in, wdata_in;
  logic [7:0]  seg_o, an_o;
  logic        change_o;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, held word, expected outputs.
  int          m_n;
  logic [31:0] m_snap;
  logic [7:0]  e_an, e_seg;
  logic        e_chg;
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  obs_display_scan #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .freeze   (freeze),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .mdr_in   (mdr_in),
    .wdata_in (wdata_in),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .change_o (change_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_word();
    case (sel)
      2'd0:    return pc_in;
      2'd1:    return ir_in;
      2'd2:    return mdr_in;
      default: return wdata_in;
    endcase
  endfunction

  // Advance one clock; expected outputs come from elapsed cycle count arithmetic.
  task automatic tick();
    int slot, pos, d;
    logic [3:0] nib;
    if (rst) begin
      e_an = 8'hFF; e_seg = 8'hFF; e_chg = 1'b0;
      m_snap = '0; m_n = 0;
    end else begin
      slot = m_n / SD;
      pos  = m_n % SD;
      d    = slot % 8;
      if (pos < BC) begin
        e_an = 8'hFF; e_seg = 8'hFF;
      end else begin
        e_an  = ~(8'h01 << d);
        nib   = 4'((m_snap >> (4 * d)) & 32'hF);
        e_seg = {(d == int'(sel)) ? 1'b0 : 1'b1, hex_tab[nib]};
      end
      if (freeze) begin
        e_chg = 1'b0;
      end else begin
        e_chg  = (src_word() != m_snap);
        m_snap = src_word();
      end
      m_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 2'($urandom); freeze = 1'($urandom);
    pc_in = $urandom; ir_in = $urandom; mdr_in = $urandom; wdata_in = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (an_o !== 8'hFF || seg_o !== 8'hFF || change_o !== 1'b0) begin
        bad++;
        $display("FAIL reset: an=%h seg=%h chg=%b want an=FF seg=FF chg=0", an_o, seg_o, change_o);
      end
    end
    rst = 1'b0; freeze = 1'b0;
    tick();
    total++;
    if (an_o !== 8'hFF || seg_o !== 8'hFF) begin
      bad++;
      $display("FAIL reset_blank: an=%h seg=%h want FF FF", an_o, seg_o);
    end
    tick();
    total++;
    if (an_o !== 8'hFE || seg_o !== e_seg) begin
      bad++;
      $display("FAIL reset_first_lit: an=%h seg=%h want an=FE seg=%h", an_o, seg_o, e_seg);
    end
  endtask

  task automatic test_scan();
    int dp_bad = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    sel = 2'd0; freeze = 1'b0; pc_in = 32'h76543210;
    for (int i = 0; i < 2 * 8 * SD + 4; i++) begin
      tick();
      total++;
      if (an_o !== e_an || seg_o !== e_seg || change_o !== e_chg) begin
        bad++;
        $display("FAIL scan: cyc=%0d an=%h seg=%h chg=%b want an=%h seg=%h chg=%b",
                 i, an_o, seg_o, change_o, e_an, e_seg, e_chg);
      end
      if (seg_o[7] === 1'b0 && an_o !== 8'hFE) dp_bad++;
    end
    total++;
    if (dp_bad != 0) begin
      bad++;
      $display("FAIL scan_dp: off-digit dp lit %0d times want 0", dp_bad);
    end
  endtask

  task automatic test_select();
    int pulses = 0;
    ir_in = 32'h00A00093; sel = 2'd1;
    for (int i = 0; i < 3 * SD * 8; i++) begin
      tick();
      total++;
      if (an_o !== e_an || seg_o !== e_seg || change_o !== e_chg) begin
        bad++;
        $display("FAIL select: cyc=%0d an=%h seg=%h chg=%b want an=%h seg=%h chg=%b",
                 i, an_o, seg_o, change_o, e_an, e_seg, e_chg);
      end
      if (change_o === 1'b1) pulses++;
      if (an_o === 8'hDF && seg_o[6:0] !== 7'h08) begin
        total++; bad++;
        $display("FAIL select_digit5: seg=%h want 08", seg_o[6:0]);
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL select_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_freeze();
    int pulses = 0;
    freeze = 1'b1;
    tick();
    wdata_in = ir_in ^ 32'h0000_1000 ^ ($urandom & 32'hFFFF_0FFF);
    sel = 2'd3;
    for (int i = 0; i < 2 * SD * 8; i++) begin
      tick();
      total++;
      if (an_o !== e_an || seg_o !== e_seg || change_o !== e_chg) begin
        bad++;
        $display("FAIL freeze: cyc=%0d an=%h seg=%h chg=%b want an=%h seg=%h chg=%b",
                 i, an_o, seg_o, change_o, e_an, e_seg, e_chg);
      end
      if (change_o === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL freeze_pulses: got %0d want 0", pulses);
    end
    freeze = 1'b0;
    tick();
    total++;
    if (change_o !== 1'b1) begin
      bad++;
      $display("FAIL unfreeze_pulse: chg=%b want 1", change_o);
    end
    tick();
    total++;
    if (change_o !== 1'b0 || seg_o !== e_seg || an_o !== e_an) begin
      bad++;
      $display("FAIL unfreeze_after: an=%h seg=%h chg=%b want an=%h seg=%h chg=0",
               an_o, seg_o, change_o, e_an, e_seg);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!((m_n % SD) == 2 && ((m_n / SD) % 8) == 5) && guard < 200) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL mid_reset_reach: model never reached digit 5 cycle 2");
    end
    rst = 1'b1;
    tick();
    total++;
    if (an_o !== 8'hFF || seg_o !== 8'hFF || change_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: an=%h seg=%h chg=%b want FF FF 0", an_o, seg_o, change_o);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (an_o !== 8'hFE || seg_o !== e_seg) begin
      bad++;
      $display("FAIL mid_reset_restart: an=%h seg=%h want FE %h", an_o, seg_o, e_seg);
    end
  endtask

  task automatic test_single_step();
    logic [31:0] steps [4] = '{32'h0, 32'h4, 32'h8, 32'h8};
    int          want  [4] = '{1, 1, 1, 0};
    int pulses;
    sel = 2'd0; freeze = 1'b0; pc_in = 32'h1;
    tick();
    for (int s = 0; s < 4; s++) begin
      pc_in  = steps[s];
      pulses = 0;
      for (int i = 0; i < 8 * SD; i++) begin
        tick();
        total++;
        if (an_o !== e_an || seg_o !== e_seg || change_o !== e_chg) begin
          bad++;
          $display("FAIL step: s=%0d an=%h seg=%h chg=%b want an=%h seg=%h chg=%b",
                   s, an_o, seg_o, change_o, e_an, e_seg, e_chg);
        end
        if (change_o === 1'b1) pulses++;
      end
      total++;
      if (pulses != want[s]) begin
        bad++;
        $display("FAIL step_pulses: s=%0d got %0d want %0d", s, pulses, want[s]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom);
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) pc_in = $urandom;
      if ($urandom_range(0, 5) == 0) ir_in = $urandom;
      if ($urandom_range(0, 5) == 0) mdr_in = $urandom;
      if ($urandom_range(0, 5) == 0) wdata_in = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (an_o !== e_an || seg_o !== e_seg || change_o !== e_chg) begin
        bad++;
        $display("FAIL random: cyc=%0d an=%h seg=%h chg=%b want an=%h seg=%h chg=%b",
                 i, an_o, seg_o, change_o, e_an, e_seg, e_chg);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_select();
    test_freeze();
    test_mid_reset();
    test_single_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
